lfsr_tpg: RTL
=============

LFSR_TPG -- requirements
Module: lfsr_tpg

Interface
REQ-001 Parameter N, default 64: LFSR / pattern width in bits.
REQ-002 Parameter CNT_W, default 16: pattern-count width in bits.
REQ-003 clk  input  1  clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle request to begin a pattern run; sampled only in IDLE.
REQ-006 seed  input  N  initial LFSR state, latched on accepted start.
REQ-007 coeff  input  N  feedback polynomial taps (bit k = x^k term), latched on accepted start.
REQ-008 num_patterns  input  CNT_W  number of patterns to emit, latched on accepted start.
REQ-009 pat_valid  output  1  pat_data holds a valid pattern.
REQ-010 pat_ready  input  1  consumer accepts the pattern this cycle.
REQ-011 pat_data  output  N  current pattern (the LFSR state register).
REQ-012 busy  output  1  high in RUN.
REQ-013 done  output  1  one-cycle pulse at end of run.

Function
REQ-014 FSM states IDLE, RUN, DONE shall be used; no other states.
REQ-015 IDLE: start=1 shall latch coeff and num_patterns, load the LFSR with seed, and go to RUN next cycle; if num_patterns=0, go to DONE instead.
REQ-016 A seed of all zeros shall be replaced by {N-1 zeros, 1} to avoid the lock-up state.
REQ-017 start shall be ignored in RUN and DONE.
REQ-018 RUN: pat_valid=1, busy=1, pat_data = LFSR state; pattern transfers when pat_valid and pat_ready are both 1.
REQ-019 The LFSR and pat_data shall hold while pat_valid=1 and pat_ready=0.
REQ-020 On each transfer, the LFSR shall advance one Galois step: next[0] = coeff[0] & q[N-1]; next[k] = q[k-1] ^ (coeff[k] & q[N-1]) for k=1..N-1. This matches the team's MISR feedback with a zero data input.
REQ-021 A CNT_W-bit counter shall clear on an accepted start and increment on each transfer.
REQ-022 A transfer with counter = num_patterns-1 shall move the FSM to DONE next cycle, with pat_valid=0 from that cycle.
REQ-023 DONE: done=1 and busy=0 for exactly one cycle, then IDLE; LFSR state is retained.
REQ-024 In IDLE and DONE, pat_valid=0; pat_data shows the LFSR state.
REQ-025 Exactly num_patterns transfers shall occur per run; sequence period is 2^N-1 for a primitive coeff, with no check for non-primitive coeff.

Reset
REQ-026 On rst_n=0, at any time including mid-run: FSM=IDLE, LFSR={N-1 zeros,1}, counter=0, latched coeff and num_patterns=0.
REQ-027 Reset values: pat_valid=0, busy=0, done=0, pat_data={N-1 zeros,1}.
REQ-028 After reset release, no pattern shall be emitted until a new start.

Structure
REQ-029 Package bist_pkg shall hold the FSM state enum typedef (tpg_state_t) and the default width constants N and CNT_W.
REQ-030 The combinational next-state function of REQ-020 shall be sub-module tpg_lfsr_core (inputs q, coeff; output next), shared with BIST checkers.
REQ-031 All registers shall be in a single always_ff block with async reset; FSM outputs shall be registered or decoded from state only, with no input-to-output combinational path.

Verification
REQ-032 N=4, coeff=4'b0011, seed=4'b0001, num_patterns=8, pat_ready=1 -> pat_data 1,2,4,8,3,6,C,B on 8 consecutive cycles, then one-cycle done.
REQ-033 Same configuration, num_patterns=15 -> 15 distinct non-zero values, and the 16th LFSR state returns to 4'b0001.
REQ-034 Same configuration, pat_ready toggled 1,0,0,1,... -> pat_data holds during stalls; the accepted sequence is identical to REQ-032.
REQ-035 seed=0 -> first pattern 4'b0001; num_patterns=0 -> no pat_valid, done 1 cycle after start.
REQ-036 start pulsed during RUN -> ignored; rst_n low after the 3rd transfer -> immediate reset values; a later start restarts from seed.

Source files
------------

// File: rtl/bist_pkg.sv
// bist_pkg: shared BIST pattern-generator state type and default widths
package bist_pkg;
  localparam int N = 64;
  localparam int CNT_W = 16;
  typedef enum logic [1:0] {IDLE, RUN, DONE} tpg_state_t;
endpackage

// File: rtl/tpg_lfsr_core.sv
// tpg_lfsr_core: one Galois LFSR step (q, coeff -> next), MISR feedback with zero data
module tpg_lfsr_core #(
  parameter int N = 64
) (
  input  logic [N-1:0] q,
  input  logic [N-1:0] coeff,
  output logic [N-1:0] next
);
  assign next = {q[N-2:0], 1'b0} ^ (coeff & {N{q[N-1]}});
endmodule

// File: rtl/lfsr_tpg.sv
// lfsr_tpg: LFSR test-pattern generator (start/seed/coeff/num_patterns in; pat_valid/pat_ready/pat_data handshake, busy, done out)
module lfsr_tpg #(
  parameter int N = bist_pkg::N,
  parameter int CNT_W = bist_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N-1:0]     seed,
  input  logic [N-1:0]     coeff,
  input  logic [CNT_W-1:0] num_patterns,
  output logic             pat_valid,
  input  logic             pat_ready,
  output logic [N-1:0]     pat_data,
  output logic             busy,
  output logic             done
);
  import bist_pkg::*;
  localparam logic [N-1:0] ONE = N'(1);
  tpg_state_t state_q, state_d;
  logic [N-1:0] lfsr_q, lfsr_d, coeff_q, coeff_d, step;
  logic [CNT_W-1:0] cnt_q, cnt_d, num_q, num_d;
  logic xfer;
  tpg_lfsr_core #(.N(N)) u_core (.q(lfsr_q), .coeff(coeff_q), .next(step));
  assign xfer = (state_q == RUN) && pat_ready;
  always_comb begin
    state_d = state_q;
    lfsr_d = lfsr_q;
    coeff_d = coeff_q;
    num_d = num_q;
    cnt_d = cnt_q;
    if (state_q == IDLE && start) begin
      lfsr_d = (seed == '0) ? ONE : seed;
      coeff_d = coeff;
      num_d = num_patterns;
      cnt_d = '0;
      state_d = (num_patterns == '0) ? DONE : RUN;
    end else if (xfer) begin
      lfsr_d = step;
      cnt_d = cnt_q + CNT_W'(1);
      state_d = (cnt_q == num_q - CNT_W'(1)) ? DONE : RUN;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lfsr_q <= ONE;
      coeff_q <= '0;
      num_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q <= lfsr_d;
      coeff_q <= coeff_d;
      num_q <= num_d;
      cnt_q <= cnt_d;
    end
  end
  assign pat_valid = (state_q == RUN);
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign pat_data = lfsr_q;
endmodule
